// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants, twiddle ROM and state type for the 32-point FFT/IFFT datapath
package fft_pkg;

  localparam int N       = 32;
  localparam int LOG2N   = 5;
  localparam int DW      = 32;
  localparam int TW      = 16;
  localparam int TW_FRAC = 14;

  typedef enum logic [1:0] {LOAD, CALC, OUT} state_e;

  // exp(+j*2*pi*k/32) for k = 0..15, Q2.14
  localparam logic signed [TW-1:0] COS_ROM [16] = '{
    16'sd16384,  16'sd16069,  16'sd15137,  16'sd13623,
    16'sd11585,  16'sd9102,   16'sd6270,   16'sd3196,
    16'sd0,     -16'sd3196,  -16'sd6270,  -16'sd9102,
   -16'sd11585, -16'sd13623, -16'sd15137, -16'sd16069
  };

  localparam logic signed [TW-1:0] SIN_ROM [16] = '{
    16'sd0,      16'sd3196,   16'sd6270,   16'sd9102,
    16'sd11585,  16'sd13623,  16'sd15137,  16'sd16069,
    16'sd16384,  16'sd16069,  16'sd15137,  16'sd13623,
    16'sd11585,  16'sd9102,   16'sd6270,   16'sd3196
  };

  function automatic logic [LOG2N-1:0] bitrev5(input logic [LOG2N-1:0] v);
    return {v[0], v[1], v[2], v[3], v[4]};
  endfunction

endpackage

// File: rtl/ifft_bfly_r2.sv
// rtl/ifft_bfly_r2.sv - combinational radix-2 butterfly: x=(a+W*b)>>>1, y=(a-W*b)>>>1
module ifft_bfly_r2
  import fft_pkg::*;
(
  input  logic [DW-1:0] a_re_i,
  input  logic [DW-1:0] a_im_i,
  input  logic [DW-1:0] b_re_i,
  input  logic [DW-1:0] b_im_i,
  input  logic [TW-1:0] w_re_i,
  input  logic [TW-1:0] w_im_i,
  output logic [DW-1:0] x_re_o,
  output logic [DW-1:0] x_im_o,
  output logic [DW-1:0] y_re_o,
  output logic [DW-1:0] y_im_o
);

  localparam int PW = DW + TW + 1;
  localparam int SW = DW + 2;

  logic signed [PW-1:0] br, bi, wr, wi;
  logic signed [PW-1:0] t_re_full, t_im_full, t_re_sh, t_im_sh;
  logic signed [SW-1:0] t_re, t_im, a_re, a_im;
  logic signed [SW-1:0] s_re, s_im, d_re, d_im;
  logic                 unused_bits;

  assign br = {{(PW-DW){b_re_i[DW-1]}}, b_re_i};
  assign bi = {{(PW-DW){b_im_i[DW-1]}}, b_im_i};
  assign wr = {{(PW-TW){w_re_i[TW-1]}}, w_re_i};
  assign wi = {{(PW-TW){w_im_i[TW-1]}}, w_im_i};

  assign t_re_full = br * wr - bi * wi;
  assign t_im_full = br * wi + bi * wr;
  assign t_re_sh   = t_re_full >>> TW_FRAC;
  assign t_im_sh   = t_im_full >>> TW_FRAC;
  // |W*b| stays below 2^33, so DW+2 bits hold the product exactly
  assign t_re      = t_re_sh[SW-1:0];
  assign t_im      = t_im_sh[SW-1:0];

  assign a_re = {{2{a_re_i[DW-1]}}, a_re_i};
  assign a_im = {{2{a_im_i[DW-1]}}, a_im_i};
  assign s_re = a_re + t_re;
  assign s_im = a_im + t_im;
  assign d_re = a_re - t_re;
  assign d_im = a_im - t_im;

  assign x_re_o = s_re[SW-2:1];
  assign x_im_o = s_im[SW-2:1];
  assign y_re_o = d_re[SW-2:1];
  assign y_im_o = d_im[SW-2:1];

  assign unused_bits = ^{t_re_sh[PW-1:SW], t_im_sh[PW-1:SW],
                         s_re[SW-1], s_re[0], s_im[SW-1], s_im[0],
                         d_re[SW-1], d_re[0], d_im[SW-1], d_im[0]};

endmodule

// File: rtl/ifft_32p_32bits_seq.sv
// rtl/ifft_32p_32bits_seq.sv - sequential in-place 32-point radix-2 DIT inverse FFT
// Optional IFFT_STAGE_SEL_EN adds stage_sel to stop after the first stage_sel stages.
module ifft_32p_32bits_seq
  import fft_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_real,
  input  logic [DW-1:0] in_imag,
  input  logic          in_valid,
  output logic          in_ready,
`ifdef IFFT_STAGE_SEL_EN
  input  logic [2:0]    stage_sel,
`endif
  output logic [DW-1:0] out_real,
  output logic [DW-1:0] out_imag,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          busy
);

  state_e        state_q, state_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [2:0]    stage_q, stage_d;
  logic [2:0]    nstages_q, nstages_d;
  logic [3:0]    bfly_q, bfly_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic [DW-1:0] out_real_q, out_real_d;
  logic [DW-1:0] out_imag_q, out_imag_d;

  logic [DW-1:0] mem_re_q [N];
  logic [DW-1:0] mem_im_q [N];

  logic          calc_act;
  logic [4:0]    b5, span, low, p_idx, q_idx;
  logic [3:0]    k_idx;
  logic [DW-1:0] x_re, x_im, y_re, y_im;
  logic [2:0]    sel_stages;

`ifdef IFFT_STAGE_SEL_EN
  assign sel_stages = (stage_sel > 3'd5) ? 3'd5 : stage_sel;
`else
  assign sel_stages = 3'd5;
`endif

  assign calc_act = (state_q == CALC) && (stage_q < nstages_q);

  always_comb begin
    b5    = {1'b0, bfly_q};
    span  = 5'd1 << stage_q;
    low   = b5 & (span - 5'd1);
    p_idx = ((b5 >> stage_q) << (stage_q + 3'd1)) | low;
    q_idx = p_idx | span;
    k_idx = 4'(low << (3'd4 - stage_q));
  end

  ifft_bfly_r2 u_bfly (
    .a_re_i (mem_re_q[p_idx]),
    .a_im_i (mem_im_q[p_idx]),
    .b_re_i (mem_re_q[q_idx]),
    .b_im_i (mem_im_q[q_idx]),
    .w_re_i (COS_ROM[k_idx]),
    .w_im_i (SIN_ROM[k_idx]),
    .x_re_o (x_re),
    .x_im_o (x_im),
    .y_re_o (y_re),
    .y_im_o (y_im)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stage_d     = stage_q;
    nstages_d   = nstages_q;
    bfly_d      = bfly_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_real_d  = out_real_q;
    out_imag_d  = out_imag_q;
    case (state_q)
      LOAD: begin
        if (in_valid) begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d   = CALC;
            stage_d   = 3'd0;
            bfly_d    = 4'd0;
            nstages_d = sel_stages;
          end
        end
      end
      CALC: begin
        if (!calc_act) begin
          state_d = OUT;
        end else begin
          bfly_d = bfly_q + 4'd1;
          if (bfly_q == 4'd15) begin
            stage_d = stage_q + 3'd1;
            if (stage_q == nstages_q - 3'd1) state_d = OUT;
          end
        end
      end
      OUT: begin
        // output register refills on every accepted beat until the last one
        if (out_valid_q && out_ready && out_last_q) begin
          state_d     = LOAD;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          cnt_d       = 5'd0;
        end else if (!out_valid_q || out_ready) begin
          out_real_d  = mem_re_q[cnt_q];
          out_imag_d  = mem_im_q[cnt_q];
          out_valid_d = 1'b1;
          out_last_d  = (cnt_q == 5'd31);
          cnt_d       = cnt_q + 5'd1;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD;
      cnt_q       <= 5'd0;
      stage_q     <= 3'd0;
      nstages_q   <= 3'd5;
      bfly_q      <= 4'd0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_real_q  <= '0;
      out_imag_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stage_q     <= stage_d;
      nstages_q   <= nstages_d;
      bfly_q      <= bfly_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_real_q  <= out_real_d;
      out_imag_q  <= out_imag_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == LOAD && in_valid) begin
      mem_re_q[bitrev5(cnt_q)] <= in_real;
      mem_im_q[bitrev5(cnt_q)] <= in_imag;
    end else if (calc_act) begin
      mem_re_q[p_idx] <= x_re;
      mem_im_q[p_idx] <= x_im;
      mem_re_q[q_idx] <= y_re;
      mem_im_q[q_idx] <= y_im;
    end
  end

  assign in_ready  = (state_q == LOAD);
  assign busy      = (state_q != LOAD);
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_real  = out_real_q;
  assign out_imag  = out_imag_q;

endmodule

// File: tb/tb_ifft_32p_32bits_seq.sv
// tb/tb_ifft_32p_32bits_seq.sv - directed self-checking bench for ifft_32p_32bits_seq
module tb_ifft_32p_32bits_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_real, in_imag;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_real, out_imag;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int lat;

  logic [31:0] bin_re [32];
  logic [31:0] bin_im [32];
  logic [31:0] res_re [32];
  logic [31:0] res_im [32];
  logic        res_last [32];

  always #5 clk = ~clk;

  ifft_32p_32bits_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_real   (in_real),
    .in_imag   (in_imag),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_real  (out_real),
    .out_imag  (out_imag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_near(input string tag, input logic [31:0] obs, input longint exp_v);
    longint d;
    d = longint'($signed(obs)) - exp_v;
    checks++;
    assert ((d >= -100) && (d <= 100)) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d+-100", tag, $signed(obs), exp_v);
    end
  endtask

  task automatic clear_bins();
    for (int i = 0; i < 32; i++) begin
      bin_re[i] = 32'h0;
      bin_im[i] = 32'h0;
    end
  endtask

  task automatic send_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      in_valid = 1'b1;
      in_real  = bin_re[i];
      in_imag  = bin_im[i];
      tick();
    end
    in_valid = 1'b0;
    in_real  = 32'h0;
    in_imag  = 32'h0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
  endtask

  task automatic recv(input bit bp);
    int idx = 0;
    int cyc = 0;
    bit stalled = 0;
    logic [31:0] hr, hi;
    logic hl;
    while (idx < 32 && cyc < 400) begin
      out_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      #0;
      if (stalled) begin
        chk("hold_real", out_real, hr);
        chk("hold_imag", out_imag, hi);
        chk("hold_last", out_last, hl);
        stalled = 0;
      end
      if (out_valid && out_ready) begin
        res_re[idx]   = out_real;
        res_im[idx]   = out_imag;
        res_last[idx] = out_last;
        chk("in_ready_during_out", in_ready, 0);
        idx++;
      end else if (out_valid) begin
        stalled = 1;
        hr = out_real;
        hi = out_imag;
        hl = out_last;
      end
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    chk("transfers", idx, 32);
    chk("post_in_ready", in_ready, 1);
    chk("post_busy", busy, 0);
    chk("post_out_valid", out_valid, 0);
  endtask

  task automatic check_tone();
    chk_near("tone_x0_re", res_re[0], 65536);
    chk_near("tone_x0_im", res_im[0], 0);
    chk_near("tone_x4_re", res_re[4], 46341);
    chk_near("tone_x4_im", res_im[4], 46341);
    chk_near("tone_x8_re", res_re[8], 0);
    chk_near("tone_x8_im", res_im[8], 65536);
    chk_near("tone_x16_re", res_re[16], -65536);
    chk_near("tone_x16_im", res_im[16], 0);
    chk_near("tone_x24_re", res_re[24], 0);
    chk_near("tone_x24_im", res_im[24], -65536);
  endtask

  initial begin
    rst       = 1'b1;
    in_real   = 32'h0;
    in_imag   = 32'h0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_real", out_real, 0);
    chk("rst_out_imag", out_imag, 0);
    rst = 1'b0;
    tick();

    // DC bin, loaded in two bursts with an idle gap
    clear_bins();
    bin_re[0] = 32'h0020_0000;
    send_range(0, 9);
    repeat (50) tick();
    chk("partial_out_valid", out_valid, 0);
    chk("partial_in_ready", in_ready, 1);
    chk("partial_busy", busy, 0);
    send_range(10, 31);
    chk("calc_busy", busy, 1);
    chk("calc_in_ready", in_ready, 0);
    wait_out(lat);
    chk("latency", lat, 81);
    recv(0);
    for (int i = 0; i < 32; i++) begin
      chk_near("dc_re", res_re[i], 65536);
      chk_near("dc_im", res_im[i], 0);
      chk("dc_last", res_last[i], (i == 31));
    end

    // flat spectrum
    clear_bins();
    for (int i = 0; i < 32; i++) bin_re[i] = 32'h0001_0000;
    send_range(0, 31);
    wait_out(lat);
    chk("flat_started", out_valid, 1);
    recv(0);
    for (int i = 0; i < 32; i++) begin
      chk_near("flat_re", res_re[i], (i == 0) ? 65536 : 0);
      chk_near("flat_im", res_im[i], 0);
    end

    // single tone with junk on the input side during CALC
    clear_bins();
    bin_re[1] = 32'h0020_0000;
    send_range(0, 31);
    in_valid = 1'b1;
    in_real  = 32'h1234_5678;
    in_imag  = 32'h8765_4321;
    wait_out(lat);
    in_valid = 1'b0;
    in_real  = 32'h0;
    in_imag  = 32'h0;
    chk("tone_started", out_valid, 1);
    recv(0);
    check_tone();

    // full scale
    clear_bins();
    for (int i = 0; i < 32; i++) bin_re[i] = 32'h7FFF_FFFF;
    send_range(0, 31);
    wait_out(lat);
    chk("full_started", out_valid, 1);
    recv(0);
    for (int i = 0; i < 32; i++) begin
      chk("full_re", res_re[i], (i == 0) ? 32'h7FFF_FFFF : 32'h0);
      chk("full_im", res_im[i], 32'h0);
    end

    // tone under backpressure
    clear_bins();
    bin_re[1] = 32'h0020_0000;
    send_range(0, 31);
    wait_out(lat);
    chk("bp_started", out_valid, 1);
    recv(1);
    check_tone();

    // reset during CALC cycle 40, then a fresh DC frame
    clear_bins();
    bin_re[1] = 32'h0020_0000;
    send_range(0, 31);
    repeat (39) tick();
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_out_valid", out_valid, 0);
    clear_bins();
    bin_re[0] = 32'h0020_0000;
    send_range(0, 31);
    wait_out(lat);
    chk("abort_latency", lat, 81);
    recv(0);
    for (int i = 0; i < 32; i++) begin
      chk_near("redc_re", res_re[i], 65536);
      chk_near("redc_im", res_im[i], 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
